// File: rtl/adxl355_pkg.sv
// adxl355_pkg: shared constants and types for the ADXL355 frame buffer.
//   FRAME_LEN_DEFAULT - bytes per sample frame (9 per ADXL, two devices)
//   wr_state_t        - write-side FSM state encoding
//   ptr_width()       - pointer width for a given BRAM address width; one
//                       extra bit distinguishes a full buffer from an empty one
package adxl355_pkg;

    localparam int FRAME_LEN_DEFAULT = 18;
    localparam int PTR_EXTRA_BITS    = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DROP = 2'd2
    } wr_state_t;

    function automatic int ptr_width(input int addr_bits);
        return addr_bits + PTR_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/bram_sdp.sv
// bram_sdp: simple dual-port byte RAM, one write port and one registered
// read port, depth 2**addr_bits.
//   clk     - clock for both ports
//   reset   - async active-high reset of the read data register only
//   we      - write enable, waddr/wdata written on the rising edge
//   re      - read enable, rdata <= mem[raddr] on the rising edge
module bram_sdp #(
    parameter int addr_bits = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [addr_bits-1:0] waddr,
    input  logic [7:0]           wdata,
    input  logic                 re,
    input  logic [addr_bits-1:0] raddr,
    output logic [7:0]           rdata
);

    logic [7:0] mem [2**addr_bits];

    // NOTE: the array has no reset so it maps onto block RAM; only the read
    // register is reset, which is all the outside world can observe.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/adxl355_frame_buf.sv
// adxl355_frame_buf: stores whole sample frames from the SPI reader in a
// circular BRAM FIFO. Bytes of a frame land in memory via a working write
// pointer; only when the last byte arrives does the committed pointer move,
// so the reader never sees a partial frame. A frame that cannot fit is
// dropped and flagged in the sticky overflow bit.
//   clk, reset         - clock, async active-high reset
//   wrdata, wr         - byte stream from the SPI reader
//   x                  - frame-start pulse, precedes the first wr of a frame
//   rd_en              - pop request; ignored when empty
//   rd_data, rd_valid  - popped byte, valid one clock after an accepted rd_en
//   fill, empty        - committed bytes available to read
//   frame_done         - 1-clk pulse when a frame commits
//   overflow, clr_ovf  - sticky dropped-frame flag and its clear
module adxl355_frame_buf
    import adxl355_pkg::*;
#(
    parameter int addr_bits = 10,
    parameter int frame_len = FRAME_LEN_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         wrdata,
    input  logic               wr,
    input  logic               x,
    input  logic               rd_en,
    output logic [7:0]         rd_data,
    output logic               rd_valid,
    output logic [addr_bits:0] fill,
    output logic               empty,
    output logic               frame_done,
    output logic               overflow,
    input  logic               clr_ovf
);

    localparam int PTR_W = ptr_width(addr_bits);
    localparam logic [PTR_W-1:0] DEPTH       = PTR_W'(2**addr_bits);
    localparam logic [PTR_W-1:0] FRAME_LEN_P = PTR_W'(frame_len);
    localparam logic [PTR_W-1:0] CNT_LAST    = PTR_W'(frame_len - 1);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

    generate
        if (frame_len > 2**addr_bits || frame_len < 1) begin : g_bad_frame_len
            $error("adxl355_frame_buf: frame_len must be in 1..2**addr_bits");
        end
    endgenerate

    wr_state_t        state;
    logic [PTR_W-1:0] wptr_commit;
    logic [PTR_W-1:0] wptr_work;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] cnt;
    logic [PTR_W-1:0] free;
    logic             rd_accept;
    logic             ram_we;

    // Pointers carry one extra bit, so plain modular subtraction gives the
    // occupancy even after wrapping, and fill == DEPTH is distinguishable.
    assign fill      = wptr_commit - rptr;
    assign empty     = (fill == '0);
    assign free      = DEPTH - fill;
    assign rd_accept = rd_en && !empty;
    // x wins over a same-cycle wr, so that byte is never written.
    assign ram_we    = (state == ST_FILL) && wr && !x;

    bram_sdp #(
        .addr_bits (addr_bits)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (wptr_work[addr_bits-1:0]),
        .wdata (wrdata),
        .re    (rd_accept),
        .raddr (rptr[addr_bits-1:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            wptr_commit <= '0;
            wptr_work   <= '0;
            rptr        <= '0;
            cnt         <= '0;
            rd_valid    <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            rd_valid   <= rd_accept;

            if (rd_accept) begin
                rptr <= rptr + PTR_ONE;
            end

            // The drop branch below assigns later, so a same-cycle drop
            // takes precedence over the clear.
            if (clr_ovf) begin
                overflow <= 1'b0;
            end

            if (x) begin
                // free is computed from this cycle's rptr: a pop in the same
                // cycle does not make room for this frame.
                if (free >= FRAME_LEN_P) begin
                    state     <= ST_FILL;
                    wptr_work <= wptr_commit;
                    cnt       <= '0;
                end else begin
                    state    <= ST_DROP;
                    overflow <= 1'b1;
                end
            end else begin
                case (state)
                    ST_FILL: begin
                        if (wr) begin
                            wptr_work <= wptr_work + PTR_ONE;
                            cnt       <= cnt + PTR_ONE;
                            if (cnt == CNT_LAST) begin
                                wptr_commit <= wptr_work + PTR_ONE;
                                frame_done  <= 1'b1;
                                state       <= ST_IDLE;
                            end
                        end
                    end
                    // IDLE ignores stray bytes; DROP waits for the next x.
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adxl355_frame_buf.sv
// Directed testbench for adxl355_frame_buf (addr_bits=6, 64-byte buffer).
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// the same point, i.e. they reflect the edge just taken.
module tb_adxl355_frame_buf;

    localparam int AB = 6;
    localparam int FL = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    wrdata = '0;
    logic          wr = 1'b0;
    logic          x = 1'b0;
    logic          rd_en = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [AB:0]   fill;
    logic          empty;
    logic          frame_done;
    logic          overflow;
    logic          clr_ovf = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    adxl355_frame_buf #(
        .addr_bits (AB),
        .frame_len (FL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wrdata     (wrdata),
        .wr         (wr),
        .x          (x),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fill       (fill),
        .empty      (empty),
        .frame_done (frame_done),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_x();
        x = 1'b1;
        tick();
        x = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        wr = 1'b1;
        wrdata = b;
        tick();
        wr = 1'b0;
    endtask

    // x followed by FL bytes base, base+1, ...; the bytes are queued as
    // expected read data only when the caller knows the frame should commit.
    task automatic send_frame(input logic [7:0] base, input bit commits);
        send_x();
        for (int i = 0; i < FL; i++) begin
            send_byte(base + 8'(i));
            if (commits) exp_q.push_back(base + 8'(i));
        end
    endtask

    task automatic drain(input int n, input string tag);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check({tag, "_valid"}, 32'(rd_valid), 32'd1);
            check({tag, "_data"}, 32'(rd_data), 32'(e));
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // 1. Single frame 0x00..0x11
        send_x();
        for (int i = 0; i < FL - 1; i++) begin
            send_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        check("t1_fill_before_last", 32'(fill), 32'd0);
        check("t1_no_done_early", 32'(frame_done), 32'd0);
        send_byte(8'h11);
        exp_q.push_back(8'h11);
        check("t1_frame_done", 32'(frame_done), 32'd1);
        check("t1_fill", 32'(fill), 32'd18);
        tick();
        check("t1_done_one_clk", 32'(frame_done), 32'd0);
        drain(FL, "t1_pop");
        check("t1_empty", 32'(empty), 32'd1);

        // 2. Aborted frame
        send_x();
        for (int i = 0; i < 5; i++) send_byte(8'h55);
        send_frame(8'hA0, 1'b1);
        check("t2_fill", 32'(fill), 32'd18);
        drain(FL, "t2_pop");
        check("t2_empty", 32'(empty), 32'd1);

        // 3. Overflow: 3 frames fit (54), the 4th does not (free = 10)
        send_frame(8'h10, 1'b1);
        send_frame(8'h40, 1'b1);
        send_frame(8'h70, 1'b1);
        check("t3_fill54", 32'(fill), 32'd54);
        send_x();
        check("t3_overflow_set", 32'(overflow), 32'd1);
        for (int i = 0; i < FL; i++) begin
            send_byte(8'hC0 + 8'(i));
            check("t3_no_frame_done", 32'(frame_done), 32'd0);
        end
        check("t3_fill_still54", 32'(fill), 32'd54);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t3_overflow_clr", 32'(overflow), 32'd0);
        clr_ovf = 1'b1;
        x = 1'b1;
        tick();
        clr_ovf = 1'b0;
        x = 1'b0;
        check("t3_set_wins", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t3_overflow_clr2", 32'(overflow), 32'd0);
        drain(54, "t3_pop");
        check("t3_empty", 32'(empty), 32'd1);

        // 4. Wrap: 10 frames of incrementing data, drained after each commit
        for (int f = 0; f < 10; f++) begin
            send_frame(8'(f * FL), 1'b1);
            check("t4_frame_done", 32'(frame_done), 32'd1);
            check("t4_fill", 32'(fill), 32'd18);
            drain(FL, "t4_pop");
        end
        check("t4_fill_zero", 32'(fill), 32'd0);

        // 5. Reset mid-fill with data committed, overflow set, rd_valid high
        send_frame(8'h01, 1'b1);
        send_frame(8'h21, 1'b1);
        send_frame(8'h41, 1'b1);
        send_x();
        check("t5_overflow_pre", 32'(overflow), 32'd1);
        drain(FL, "t5_pop");
        send_x();
        for (int i = 0; i < 7; i++) send_byte(8'h99);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t5_rd_valid_pre", 32'(rd_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_fill", 32'(fill), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_overflow", 32'(overflow), 32'd0);
        check("t5_rd_valid", 32'(rd_valid), 32'd0);
        tick();
        reset = 1'b0;
        exp_q.delete();
        tick();
        send_frame(8'h60, 1'b1);
        check("t5_frame_done", 32'(frame_done), 32'd1);
        check("t5_fill_after", 32'(fill), 32'd18);
        drain(FL, "t5_pop2");

        // 6a. rd_en while empty
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t6_empty_no_valid", 32'(rd_valid), 32'd0);
        check("t6_empty_fill", 32'(fill), 32'd0);

        // 6b. Pop on the commit cycle: 18 + 18 - 1 = 35
        send_frame(8'h80, 1'b1);
        send_x();
        for (int i = 0; i < FL - 1; i++) begin
            send_byte(8'h90 + 8'(i));
        end
        rd_en = 1'b1;
        send_byte(8'h90 + 8'(FL - 1));
        rd_en = 1'b0;
        check("t6_commit_pop_fill", 32'(fill), 32'd35);
        check("t6_commit_pop_valid", 32'(rd_valid), 32'd1);
        check("t6_commit_pop_data", 32'(rd_data), 32'h80);
        void'(exp_q.pop_front());
        for (int i = 0; i < FL; i++) exp_q.push_back(8'h90 + 8'(i));
        drain(35, "t6_pop");
        check("t6_empty", 32'(empty), 32'd1);

        // 6c. Same-cycle x + wr: 0xEE is not part of the frame
        x = 1'b1;
        wr = 1'b1;
        wrdata = 8'hEE;
        tick();
        x = 1'b0;
        wr = 1'b0;
        for (int i = 0; i < FL - 1; i++) begin
            send_byte(8'h30 + 8'(i));
            exp_q.push_back(8'h30 + 8'(i));
        end
        check("t6_xwr_not_done", 32'(frame_done), 32'd0);
        send_byte(8'h30 + 8'(FL - 1));
        exp_q.push_back(8'h30 + 8'(FL - 1));
        check("t6_xwr_done", 32'(frame_done), 32'd1);
        drain(FL, "t6_xwr_pop");
        check("t6_xwr_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
